// File: rtl/trigger_pkg.sv
// rtl/trigger_pkg.sv - shared types and constants for the trigger pulse emitter
//
// Purpose : FSM state encoding, source-select encoding and default field widths
//           used by trigger_pulse_emitter and its helpers.
// Ports   : none (package)

package trigger_pkg;

    localparam int DEFAULT_CNT_WIDTH  = 16;
    localparam int DEFAULT_TIME_WIDTH = 8;

    localparam logic SOURCE_PERIODIC = 1'b0;
    localparam logic SOURCE_FORWARD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_HIGH  = 3'd3,
        ST_GAP   = 3'd4
    } trig_state_t;

endpackage

// File: rtl/trigger_edge_sync.sv
// rtl/trigger_edge_sync.sv - two-flop synchroniser with rising-edge detect
//
// Purpose : brings an asynchronous level into the clk domain and flags its
//           rising edges. An edge presented at sampling edge n is flagged
//           in the cycle following clock edge n+1.
// Ports   : clk      - system clock
//           rst_n    - asynchronous active-low reset, clears all flops
//           async_in - asynchronous input level
//           rise     - one-cycle rising-edge flag (from flops only)

module trigger_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/trigger_pulse_emitter.sv
// rtl/trigger_pulse_emitter.sv - programmable trigger/sync pulse generator
//
// Purpose : emits periodic bursts or re-timed copies of LocalTrigger edges on
//           TriggerOut, with delay, width, period and holdoff control.
// Ports   : SyncClk, reset_n       - clock, asynchronous active-low reset
//           Start, Stop            - single-cycle burst start / abort
//           SourceSelect           - 0 periodic, 1 forward LocalTrigger
//           PulseDelay/PulseWidth  - delay to rise, high time (0 -> 1)
//           PulsePeriod            - rise-to-rise spacing (periodic)
//           PulseNumber            - pulses per burst, 0 = until Stop
//           LocalTrigger           - asynchronous trigger level
//           TriggerOut, Busy, Done, LostTrigger, PulseCount - registered

module trigger_pulse_emitter
    import trigger_pkg::*;
#(
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH,
    parameter int TIME_WIDTH = DEFAULT_TIME_WIDTH,
    parameter int HOLDOFF    = 4
) (
    input  logic                  SyncClk,
    input  logic                  reset_n,
    input  logic                  Start,
    input  logic                  Stop,
    input  logic                  SourceSelect,
    input  logic [TIME_WIDTH-1:0] PulseDelay,
    input  logic [TIME_WIDTH-1:0] PulseWidth,
    input  logic [CNT_WIDTH-1:0]  PulsePeriod,
    input  logic [CNT_WIDTH-1:0]  PulseNumber,
    input  logic                  LocalTrigger,
    output logic                  TriggerOut,
    output logic                  Busy,
    output logic                  Done,
    output logic                  LostTrigger,
    output logic [CNT_WIDTH-1:0]  PulseCount
);

    // Period counter must hold either PulsePeriod-1 or the effective width.
    localparam int PW          = (CNT_WIDTH > TIME_WIDTH) ? CNT_WIDTH : TIME_WIDTH;
    localparam int HOLDOFF_EFF = (HOLDOFF < 1) ? 1 : HOLDOFF;

    localparam logic [TIME_WIDTH-1:0] ONE_T       = TIME_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  ONE_C       = CNT_WIDTH'(1);
    localparam logic [PW-1:0]         ONE_P       = PW'(1);
    localparam logic [TIME_WIDTH-1:0] HOLD_RELOAD = TIME_WIDTH'(HOLDOFF_EFF - 1);

    logic rise;

    trigger_edge_sync u_edge_sync (
        .clk      (SyncClk),
        .rst_n    (reset_n),
        .async_in (LocalTrigger),
        .rise     (rise)
    );

    // Control state
    trig_state_t           state_q,     state_d;
    logic                  src_q,       src_d;
    logic [TIME_WIDTH-1:0] delay_q,     delay_d;
    logic [TIME_WIDTH-1:0] width_q,     width_d;
    logic [CNT_WIDTH-1:0]  period_q,    period_d;
    logic [CNT_WIDTH-1:0]  number_q,    number_d;
    logic [TIME_WIDTH-1:0] tmr_q,       tmr_d;
    logic [PW-1:0]         per_q,       per_d;
    logic [CNT_WIDTH-1:0]  count_q,     count_d;
    logic                  stop_pend_q, stop_pend_d;
    logic                  done_ev_q,   done_ev_d;
    logic                  lost_ev_q,   lost_ev_d;

    // Output register stage
    logic                  trigger_out_q, trigger_out_d;
    logic                  busy_q,        busy_d;
    logic                  done_q,        done_d;
    logic                  lost_q,        lost_d;
    logic [CNT_WIDTH-1:0]  pulse_count_q, pulse_count_d;

    logic                  accept;
    logic                  enter_high;
    logic                  burst_end;
    logic [TIME_WIDTH-1:0] width_eff;
    logic [PW-1:0]         period_x;
    logic [PW-1:0]         width_x;
    logic [PW-1:0]         per_reload;

    always_comb begin
        accept = (state_q == ST_IDLE) && Start && !Stop;

        // On the accepting cycle the live inputs are used directly, so the
        // first transition already sees the new configuration.
        src_d    = accept ? SourceSelect : src_q;
        delay_d  = accept ? PulseDelay   : delay_q;
        width_d  = accept ? PulseWidth   : width_q;
        period_d = accept ? PulsePeriod  : period_q;
        number_d = accept ? PulseNumber  : number_q;

        width_eff = (width_d == '0) ? ONE_T : width_d;
        period_x  = PW'(period_d);
        width_x   = PW'(width_eff);
        // Reload so that rise-to-rise = max(PulsePeriod, width+1).
        per_reload = (period_x > width_x) ? (period_x - ONE_P) : width_x;

        burst_end = (number_q != '0) && (count_q == number_q);

        state_d     = state_q;
        tmr_d       = tmr_q;
        per_d       = (per_q != '0) ? (per_q - ONE_P) : per_q;
        count_d     = count_q;
        stop_pend_d = stop_pend_q;
        done_ev_d   = 1'b0;
        lost_ev_d   = 1'b0;
        enter_high  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stop_pend_d = 1'b0;
                if (accept) begin
                    count_d = '0;
                    if (src_d == SOURCE_FORWARD) begin
                        state_d = ST_ARMED;
                    end else if (delay_d == '0) begin
                        enter_high = 1'b1;
                    end else begin
                        state_d = ST_DELAY;
                        tmr_d   = delay_d - ONE_T;
                    end
                end
            end
            ST_ARMED: begin
                if (Stop) begin
                    state_d   = ST_IDLE;
                    done_ev_d = 1'b1;
                end else if (rise) begin
                    if (delay_q == '0) begin
                        enter_high = 1'b1;
                    end else begin
                        state_d = ST_DELAY;
                        tmr_d   = delay_q - ONE_T;
                    end
                end
            end
            ST_DELAY: begin
                lost_ev_d = rise && (src_q == SOURCE_FORWARD);
                if (Stop) begin
                    state_d   = ST_IDLE;
                    done_ev_d = 1'b1;
                end else if (tmr_q == '0) begin
                    enter_high = 1'b1;
                end else begin
                    tmr_d = tmr_q - ONE_T;
                end
            end
            ST_HIGH: begin
                lost_ev_d = rise && (src_q == SOURCE_FORWARD);
                // A Stop here is remembered so the pulse is never truncated.
                if (Stop) begin
                    stop_pend_d = 1'b1;
                end
                if (tmr_q == '0) begin
                    if (stop_pend_q || Stop || burst_end) begin
                        state_d   = ST_IDLE;
                        done_ev_d = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        tmr_d   = HOLD_RELOAD;
                    end
                end else begin
                    tmr_d = tmr_q - ONE_T;
                end
            end
            ST_GAP: begin
                lost_ev_d = rise && (src_q == SOURCE_FORWARD);
                if (Stop) begin
                    state_d   = ST_IDLE;
                    done_ev_d = 1'b1;
                end else if (src_q == SOURCE_FORWARD) begin
                    if (tmr_q == '0) begin
                        state_d = ST_ARMED;
                    end else begin
                        tmr_d = tmr_q - ONE_T;
                    end
                end else if (per_q == '0) begin
                    enter_high = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_high) begin
            state_d = ST_HIGH;
            tmr_d   = width_eff - ONE_T;
            per_d   = per_reload;
            count_d = (count_d == '1) ? count_d : (count_d + ONE_C);
        end

        // Outputs lag the control state by one register stage.
        trigger_out_d = (state_q == ST_HIGH);
        busy_d        = (state_q != ST_IDLE);
        done_d        = done_ev_q;
        lost_d        = lost_ev_q;
        pulse_count_d = count_q;
    end

    always_ff @(posedge SyncClk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            src_q         <= SOURCE_PERIODIC;
            delay_q       <= '0;
            width_q       <= '0;
            period_q      <= '0;
            number_q      <= '0;
            tmr_q         <= '0;
            per_q         <= '0;
            count_q       <= '0;
            stop_pend_q   <= 1'b0;
            done_ev_q     <= 1'b0;
            lost_ev_q     <= 1'b0;
            trigger_out_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            lost_q        <= 1'b0;
            pulse_count_q <= '0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            delay_q       <= delay_d;
            width_q       <= width_d;
            period_q      <= period_d;
            number_q      <= number_d;
            tmr_q         <= tmr_d;
            per_q         <= per_d;
            count_q       <= count_d;
            stop_pend_q   <= stop_pend_d;
            done_ev_q     <= done_ev_d;
            lost_ev_q     <= lost_ev_d;
            trigger_out_q <= trigger_out_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            lost_q        <= lost_d;
            pulse_count_q <= pulse_count_d;
        end
    end

    assign TriggerOut  = trigger_out_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign LostTrigger = lost_q;
    assign PulseCount  = pulse_count_q;

endmodule

// File: tb/tb_trigger_pulse_emitter.sv
// tb/tb_trigger_pulse_emitter.sv - scoreboard bench for trigger_pulse_emitter

module tb_trigger_pulse_emitter;

    localparam int CW = 4;
    localparam int TW = 8;

    localparam int EV_RISE = 0;
    localparam int EV_DONE = 1;
    localparam int EV_LOST = 2;

    typedef struct {
        int kind;
        int cyc;
        int cnt;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          Start, Stop, SourceSelect, LocalTrigger;
    logic [TW-1:0] PulseDelay, PulseWidth;
    logic [CW-1:0] PulsePeriod, PulseNumber;
    logic          TriggerOut, Busy, Done, LostTrigger;
    logic [CW-1:0] PulseCount;

    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;
    int  k;
    logic prev_trig = 1'b0;
    ev_t exp_q[$];

    trigger_pulse_emitter #(
        .CNT_WIDTH  (CW),
        .TIME_WIDTH (TW),
        .HOLDOFF    (4)
    ) dut (
        .SyncClk      (clk),
        .reset_n      (reset_n),
        .Start        (Start),
        .Stop         (Stop),
        .SourceSelect (SourceSelect),
        .PulseDelay   (PulseDelay),
        .PulseWidth   (PulseWidth),
        .PulsePeriod  (PulsePeriod),
        .PulseNumber  (PulseNumber),
        .LocalTrigger (LocalTrigger),
        .TriggerOut   (TriggerOut),
        .Busy         (Busy),
        .Done         (Done),
        .LostTrigger  (LostTrigger),
        .PulseCount   (PulseCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int kind);
        case (kind)
            EV_RISE: return "rise";
            EV_DONE: return "done";
            default: return "lost";
        endcase
    endfunction

    task automatic push(input int kind, input int c, input int cnt);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_ev(input int kind, input int cnt);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_%s: seen at cyc %0d count %0d, none expected",
                     kname(kind), cyc, cnt);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || (e.cnt >= 0 && e.cnt != cnt)) begin
                bad++;
                $display("FAIL event: got %s@%0d cnt=%0d expected %s@%0d cnt=%0d",
                         kname(kind), cyc, cnt, kname(e.kind), e.cyc, e.cnt);
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (TriggerOut && !prev_trig) mon_ev(EV_RISE, int'(PulseCount));
            if (Done)                     mon_ev(EV_DONE, int'(PulseCount));
            if (LostTrigger)              mon_ev(EV_LOST, -1);
        end
        prev_trig = TriggerOut;
    end

    // Inputs change 2 time units after a rising edge; cyc is that edge's index,
    // so anything driven now is sampled at edge cyc+1.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic cfg(input logic src, input int d, input int w, input int p, input int n);
        SourceSelect = src;
        PulseDelay   = TW'(d);
        PulseWidth   = TW'(w);
        PulsePeriod  = CW'(p);
        PulseNumber  = CW'(n);
    endtask

    task automatic start_burst();
        k = cyc + 1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic chk_drained(input string name);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset_n      = 1'b0;
        Start        = 1'b0;
        Stop         = 1'b0;
        LocalTrigger = 1'b0;
        cfg(1'b0, 0, 0, 0, 0);
        tick();
        tick();
        chk("reset_trig",  int'(TriggerOut),  0);
        chk("reset_busy",  int'(Busy),        0);
        chk("reset_done",  int'(Done),        0);
        chk("reset_lost",  int'(LostTrigger), 0);
        chk("reset_count", int'(PulseCount),  0);
        reset_n = 1'b1;
        tick();
        tick();

        // Periodic burst, with a mid-burst config change and a Start while busy.
        cfg(1'b0, 3, 2, 10, 4);
        start_burst();
        push(EV_RISE, k + 4, 1);
        push(EV_RISE, k + 14, 2);
        push(EV_RISE, k + 24, 3);
        push(EV_RISE, k + 34, 4);
        push(EV_DONE, k + 36, 4);
        wait_to(k + 10);
        cfg(1'b1, 0, 7, 3, 1);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("p_busy_mid", int'(Busy), 1);
        wait_to(k + 35);
        chk("p_busy_last", int'(Busy), 1);
        tick();
        chk("p_busy_end", int'(Busy), 0);
        wait_to(k + 40);
        chk("p_count", int'(PulseCount), 4);
        chk_drained("p_missing");

        // Forward mode: second edge during holdoff is lost.
        cfg(1'b1, 0, 1, 0, 0);
        start_burst();
        push(EV_RISE, k + 13, 1);
        push(EV_LOST, k + 15, -1);
        push(EV_DONE, k + 26, 1);
        wait_to(k + 9);
        LocalTrigger = 1'b1;
        tick();
        LocalTrigger = 1'b0;
        tick();
        LocalTrigger = 1'b1;
        wait_to(k + 20);
        LocalTrigger = 1'b0;
        wait_to(k + 23);
        chk("f_busy_armed", int'(Busy), 1);
        wait_to(k + 24);
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        wait_to(k + 30);
        chk("f_count", int'(PulseCount), 1);
        chk("f_busy_end", int'(Busy), 0);
        chk_drained("f_missing");

        // Stop during the third high cycle of an 8-cycle pulse.
        cfg(1'b0, 0, 8, 12, 0);
        start_burst();
        push(EV_RISE, k + 1, 1);
        push(EV_DONE, k + 9, 1);
        wait_to(k + 3);
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        wait_to(k + 8);
        chk("s_still_high", int'(TriggerOut), 1);
        tick();
        chk("s_fallen", int'(TriggerOut), 0);
        wait_to(k + 30);
        chk("s_busy_end", int'(Busy), 0);
        chk_drained("s_missing");

        // Width 0 behaves as width 1.
        cfg(1'b0, 0, 0, 3, 2);
        start_burst();
        push(EV_RISE, k + 1, 1);
        push(EV_RISE, k + 4, 2);
        push(EV_DONE, k + 5, 2);
        wait_to(k + 2);
        chk("w0_one_cycle", int'(TriggerOut), 0);
        wait_to(k + 12);
        chk_drained("w0_missing");

        // Period shorter than width: spacing becomes width+1.
        cfg(1'b0, 0, 3, 1, 2);
        start_burst();
        push(EV_RISE, k + 1, 1);
        push(EV_RISE, k + 5, 2);
        push(EV_DONE, k + 8, 2);
        wait_to(k + 4);
        chk("pw_gap_low", int'(TriggerOut), 0);
        wait_to(k + 15);
        chk_drained("pw_missing");

        // Unlimited burst; PulseCount saturates at 15.
        cfg(1'b0, 0, 1, 2, 0);
        start_burst();
        for (int i = 0; i < 18; i++) push(EV_RISE, k + 1 + 2 * i, (i + 1 > 15) ? 15 : i + 1);
        push(EV_DONE, k + 37, 15);
        wait_to(k + 35);
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        wait_to(k + 45);
        chk("sat_count", int'(PulseCount), 15);
        chk_drained("sat_missing");

        // Start and Stop together while idle: nothing happens.
        cfg(1'b0, 0, 1, 2, 1);
        Start = 1'b1;
        Stop  = 1'b1;
        tick();
        Start = 1'b0;
        Stop  = 1'b0;
        wait_to(cyc + 10);
        chk("ss_busy", int'(Busy), 0);
        chk("ss_count_held", int'(PulseCount), 15);

        // Asynchronous reset mid-pulse, then a fresh burst.
        cfg(1'b0, 0, 4, 10, 0);
        start_burst();
        push(EV_RISE, k + 1, 1);
        wait_to(k + 2);
        chk("r_high_before", int'(TriggerOut), 1);
        reset_n = 1'b0;
        #1;
        chk("r_trig_async",  int'(TriggerOut), 0);
        chk("r_busy_async",  int'(Busy),       0);
        chk("r_count_async", int'(PulseCount), 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk_drained("r_missing");
        cfg(1'b0, 1, 1, 5, 1);
        start_burst();
        push(EV_RISE, k + 2, 1);
        push(EV_DONE, k + 3, 1);
        wait_to(k + 10);
        chk("r_fresh_count", int'(PulseCount), 1);
        chk("r_fresh_busy", int'(Busy), 0);
        chk_drained("r_fresh_missing");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
